// File: rtl/clic_nest_pkg.sv
//------------------------------------------------------------------------------
// Module : common_pkg
// Brief  : Default configuration constants and types shared by the CLIC.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package common_pkg;

    localparam int CLIC_N_IRQ       = 8;
    localparam int CLIC_PRIO_W      = 3;
    localparam int CLIC_STACK_DEPTH = 4;

    typedef logic [CLIC_PRIO_W-1:0]           clic_prio_t;
    typedef logic [$clog2(CLIC_N_IRQ+1)-1:0]  clic_idx_t;

endpackage

`default_nettype wire

// File: rtl/clic_nest_arb.sv
//------------------------------------------------------------------------------
// Module : clic_arb
// Brief  : Combinational max-priority reduction tree; ties go to the higher index.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module clic_arb
    import common_pkg::*;
#(
    parameter int N_IRQ  = CLIC_N_IRQ,
    parameter int PRIO_W = CLIC_PRIO_W,
    parameter int IDX_W  = $clog2(N_IRQ+1)
) (
    input  logic [N_IRQ-1:0]        cand,
    input  logic [N_IRQ*PRIO_W-1:0] prio_vec,
    output logic                    valid,
    output logic [IDX_W-1:0]        idx,
    output logic [PRIO_W-1:0]       prio
);

    localparam int C_LEAVES = 1 << $clog2(N_IRQ);

    logic              w_v [C_LEAVES];
    logic [IDX_W-1:0]  w_i [C_LEAVES];
    logic [PRIO_W-1:0] w_p [C_LEAVES];

    always_comb begin
        for (int l = 0; l < C_LEAVES; l++) begin
            if (l < N_IRQ) begin
                w_v[l] = cand[l];
                w_i[l] = IDX_W'(l);
                w_p[l] = prio_vec[l*PRIO_W +: PRIO_W];
            end else begin
                w_v[l] = 1'b0;
                w_i[l] = '0;
                w_p[l] = '0;
            end
        end
        // In-place pairwise reduction; the odd (higher-index) entry wins ties.
        for (int w = C_LEAVES / 2; w >= 1; w = w / 2) begin
            for (int k = 0; k < w; k++) begin
                if (w_v[2*k+1] && (!w_v[2*k] || (w_p[2*k+1] >= w_p[2*k]))) begin
                    w_v[k] = 1'b1;
                    w_i[k] = w_i[2*k+1];
                    w_p[k] = w_p[2*k+1];
                end else begin
                    w_v[k] = w_v[2*k];
                    w_i[k] = w_i[2*k];
                    w_p[k] = w_p[2*k];
                end
            end
        end
        valid = w_v[0];
        idx   = w_v[0] ? w_i[0] : IDX_W'(N_IRQ);
        prio  = w_v[0] ? w_p[0] : '0;
    end

endmodule

`default_nettype wire

// File: rtl/clic_nest.sv
//------------------------------------------------------------------------------
// Module : clic_nest
// Brief  : Core-local interrupt controller with nested-preemption threshold
//          stack. Define CLIC_EDGE_EN to build edge-triggered source support.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module clic_nest
    import common_pkg::*;
#(
    parameter int N_IRQ       = CLIC_N_IRQ,
    parameter int PRIO_W      = CLIC_PRIO_W,
    parameter int STACK_DEPTH = CLIC_STACK_DEPTH,
    parameter int IDX_W       = $clog2(N_IRQ+1),
    parameter int DEPTH_W     = $clog2(STACK_DEPTH+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_IRQ-1:0]   irq_src,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [PRIO_W-1:0]  cfg_prio,
    input  logic               cfg_en,
    input  logic               cfg_edge,
    output logic               irq_req,
    output logic [IDX_W-1:0]   irq_id,
    output logic [PRIO_W-1:0]  irq_prio,
    input  logic               irq_ack,
    input  logic               irq_ret,
    output logic [PRIO_W-1:0]  threshold,
    output logic [DEPTH_W-1:0] depth,
    output logic               err
);

    localparam int                 C_SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [IDX_W-1:0]   C_NONE = IDX_W'(N_IRQ);
    localparam logic [DEPTH_W-1:0] C_FULL = DEPTH_W'(STACK_DEPTH);

    logic [N_IRQ-1:0]        r_pend;
    logic [N_IRQ-1:0]        r_en;
    logic [N_IRQ*PRIO_W-1:0] r_prio;
    logic [PRIO_W-1:0]       r_stack [STACK_DEPTH];

    logic [N_IRQ-1:0]        w_sel;
    logic [N_IRQ-1:0]        w_ack_hit;
    logic [N_IRQ-1:0]        w_cand;
    logic                    w_ack;
    logic                    w_ret_ok;
    logic                    w_thr_wr;
    logic                    w_arb_valid;
    logic [IDX_W-1:0]        w_arb_idx;
    logic [PRIO_W-1:0]       w_arb_prio;

    assign w_ack    = irq_ack & irq_req;
    assign w_ret_ok = irq_ret & (depth != '0);
    assign w_thr_wr = cfg_we & (cfg_idx == C_NONE);

    always_comb begin
        for (int i = 0; i < N_IRQ; i++) begin
            w_sel[i]     = cfg_we && (cfg_idx == IDX_W'(i));
            w_ack_hit[i] = w_ack && (irq_id == IDX_W'(i));
            w_cand[i]    = r_pend[i] & r_en[i] & (r_prio[i*PRIO_W +: PRIO_W] > threshold);
        end
    end

`ifdef CLIC_EDGE_EN
    logic [N_IRQ-1:0] r_edge;
    logic [N_IRQ-1:0] r_src_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge  <= '0;
            r_src_q <= '0;
        end else begin
            r_src_q <= irq_src;
            for (int i = 0; i < N_IRQ; i++) begin
                if (w_sel[i]) r_edge[i] <= cfg_edge;
            end
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = cfg_edge ^ (|w_ack_hit);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_en   <= '0;
            r_prio <= '0;
        end else begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (w_sel[i]) begin
                    r_en[i]                     <= cfg_en;
                    r_prio[i*PRIO_W +: PRIO_W] <= cfg_prio;
                end
`ifdef CLIC_EDGE_EN
                // A fresh edge in the ack cycle outranks the clear.
                if (r_edge[i])
                    r_pend[i] <= (r_pend[i] & ~w_ack_hit[i]) | (irq_src[i] & ~r_src_q[i]);
                else
                    r_pend[i] <= irq_src[i];
`else
                r_pend[i] <= irq_src[i];
`endif
            end
        end
    end

    clic_arb #(
        .N_IRQ  (N_IRQ),
        .PRIO_W (PRIO_W),
        .IDX_W  (IDX_W)
    ) u_arb (
        .cand     (w_cand),
        .prio_vec (r_prio),
        .valid    (w_arb_valid),
        .idx      (w_arb_idx),
        .prio     (w_arb_prio)
    );

    // Squash for one cycle after an accepted ack so the new threshold applies.
    always_ff @(posedge clk) begin
        if (rst || w_ack) begin
            irq_req  <= 1'b0;
            irq_id   <= C_NONE;
            irq_prio <= '0;
        end else begin
            irq_req  <= w_arb_valid;
            irq_id   <= w_arb_idx;
            irq_prio <= w_arb_prio;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            threshold <= '0;
            depth     <= '0;
            err       <= 1'b0;
            for (int s = 0; s < STACK_DEPTH; s++) r_stack[s] <= '0;
        end else begin
            if (w_ack && w_ret_ok) begin
                threshold <= irq_prio;
            end else if (w_ack) begin
                threshold <= irq_prio;
                if (depth == C_FULL) begin
                    err <= 1'b1;
                end else begin
                    r_stack[C_SP_W'(depth)] <= threshold;
                    depth                   <= depth + 1'b1;
                end
            end else if (w_ret_ok) begin
                threshold <= r_stack[C_SP_W'(depth - 1'b1)];
                depth     <= depth - 1'b1;
            end else if (w_thr_wr && (depth == '0)) begin
                threshold <= cfg_prio;
            end
            if (irq_ret && (depth == '0)) err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clic_nest.sv
//------------------------------------------------------------------------------
// Module : tb_clic_nest
// Brief  : Directed scenarios plus randomized traffic against a behavioural
//          model of the controller (N_IRQ=4, PRIO_W=3, STACK_DEPTH=2).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clic_nest;

    localparam int N  = 4;
    localparam int PW = 3;
    localparam int SD = 2;
    localparam int IW = 3;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_src;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [PW-1:0] cfg_prio;
    logic          cfg_en;
    logic          cfg_edge;
    logic          irq_req;
    logic [IW-1:0] irq_id;
    logic [PW-1:0] irq_prio;
    logic          irq_ack;
    logic          irq_ret;
    logic [PW-1:0] threshold;
    logic [DW-1:0] depth;
    logic          err;

    always #5 clk = ~clk;

    clic_nest #(.N_IRQ(N), .PRIO_W(PW), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_prio(cfg_prio),
        .cfg_en(cfg_en), .cfg_edge(cfg_edge),
        .irq_req(irq_req), .irq_id(irq_id), .irq_prio(irq_prio),
        .irq_ack(irq_ack), .irq_ret(irq_ret),
        .threshold(threshold), .depth(depth), .err(err)
    );

    // Behavioural model state
    int m_pend [N];
    int m_en   [N];
    int m_prio [N];
    int m_edge [N];
    int m_srcq [N];
    int m_thr, m_err, m_req, m_id, m_oprio;
    int m_stack [$];

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_prio[i] = 0; m_edge[i] = 0; m_srcq[i] = 0;
        end
        m_thr = 0; m_err = 0; m_req = 0; m_id = N; m_oprio = 0;
        m_stack.delete();
    endtask

    // Advance one clock; the model computes the post-edge state from the rules.
    task automatic tick();
        int n_pend [N];
        int n_en   [N];
        int n_prio [N];
        int n_edge [N];
        int n_thr, n_err, n_req, n_id, n_op, best, bp, dep, ack_acc;
        bit do_push, do_pop;
        if (rst) begin
            @(posedge clk); #1;
            model_reset();
        end else begin
            ack_acc = (irq_ack && m_req != 0) ? 1 : 0;
            best = -1; bp = 0;
            for (int i = 0; i < N; i++)
                if (m_pend[i] != 0 && m_en[i] != 0 && m_prio[i] > m_thr && (best < 0 || m_prio[i] >= bp)) begin
                    best = i; bp = m_prio[i];
                end
            n_req = (ack_acc == 0 && best >= 0) ? 1 : 0;
            n_id  = (n_req != 0) ? best : N;
            n_op  = (n_req != 0) ? bp : 0;
            for (int i = 0; i < N; i++) begin
                n_en[i] = m_en[i]; n_prio[i] = m_prio[i]; n_edge[i] = m_edge[i];
                if (m_edge[i] != 0)
                    n_pend[i] = ((m_pend[i] != 0 && !(ack_acc != 0 && m_id == i)) ||
                                 (irq_src[i] && m_srcq[i] == 0)) ? 1 : 0;
                else
                    n_pend[i] = irq_src[i] ? 1 : 0;
                if (cfg_we && int'(cfg_idx) == i) begin
                    n_en[i]   = cfg_en ? 1 : 0;
                    n_prio[i] = int'(cfg_prio);
`ifdef CLIC_EDGE_EN
                    n_edge[i] = cfg_edge ? 1 : 0;
`endif
                end
            end
            dep = m_stack.size();
            n_thr = m_thr; n_err = m_err; do_push = 0; do_pop = 0;
            if (ack_acc != 0 && irq_ret && dep > 0) begin
                n_thr = m_oprio;
            end else if (ack_acc != 0) begin
                n_thr = m_oprio;
                if (dep == SD) n_err = 1; else do_push = 1;
            end else if (irq_ret && dep > 0) begin
                n_thr = m_stack[$]; do_pop = 1;
            end else if (cfg_we && int'(cfg_idx) == N && dep == 0) begin
                n_thr = int'(cfg_prio);
            end
            if (irq_ret && dep == 0) n_err = 1;
            @(posedge clk); #1;
            if (do_push) m_stack.push_back(m_thr);
            if (do_pop) void'(m_stack.pop_back());
            for (int i = 0; i < N; i++) begin
                m_pend[i] = n_pend[i]; m_en[i] = n_en[i]; m_prio[i] = n_prio[i];
                m_edge[i] = n_edge[i]; m_srcq[i] = irq_src[i] ? 1 : 0;
            end
            m_thr = n_thr; m_err = n_err; m_req = n_req; m_id = n_id; m_oprio = n_op;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("irq_req",   int'(irq_req),   m_req);
            chk("irq_id",    int'(irq_id),    m_id);
            chk("irq_prio",  int'(irq_prio),  m_oprio);
            chk("threshold", int'(threshold), m_thr);
            chk("depth",     int'(depth),     m_stack.size());
            chk("err",       int'(err),       m_err);
        end
    end

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        irq_src = '0; cfg_we = 0; cfg_idx = '0; cfg_prio = '0; cfg_en = 0; cfg_edge = 0;
        irq_ack = 0; irq_ret = 0;
        rst = 1; tick(); rst = 0;
    endtask

    task automatic cfg(int idx, int p, int e, int ed);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_prio = PW'(p); cfg_en = (e != 0); cfg_edge = (ed != 0);
        tick();
        cfg_we = 0;
    endtask

    task automatic ack();
        irq_ack = 1; tick(); irq_ack = 0;
    endtask

    task automatic ret();
        irq_ret = 1; tick(); irq_ret = 0;
    endtask

    initial begin
        rst = 1;
        do_reset();
        chk_on = 1'b1;
        chk("reset_irq_id", int'(irq_id), 4);
        chk("reset_irq_req", int'(irq_req), 0);

        // Threshold filtering
        cfg(0, 2, 1, 0); cfg(1, 1, 1, 0); cfg(4, 2, 0, 0);
        irq_src = 4'b0011; ticks(3);
        chk("filter_req", int'(irq_req), 0);
        chk("filter_id", int'(irq_id), 4);

        // Arbitration with a tie
        do_reset();
        cfg(0, 5, 1, 0); cfg(2, 5, 1, 0); cfg(3, 3, 1, 0);
        irq_src = 4'b1101; ticks(2);
        chk("tie_id", int'(irq_id), 2);
        chk("tie_prio", int'(irq_prio), 5);

        // Nesting
        irq_src = 4'b1000; ticks(2);
        chk("nest_id3", int'(irq_id), 3);
        ack();
        chk("nest_thr3", int'(threshold), 3);
        chk("nest_d1", int'(depth), 1);
        chk("nest_squash", int'(irq_req), 0);
        irq_src = 4'b1100; cfg(2, 6, 1, 0); tick();
        chk("nest_id2", int'(irq_id), 2);
        chk("nest_prio6", int'(irq_prio), 6);
        ack();
        chk("nest_thr6", int'(threshold), 6);
        chk("nest_d2", int'(depth), 2);
        irq_src = '0;
        ret();
        chk("nest_ret_thr3", int'(threshold), 3);
        ret();
        chk("nest_ret_thr0", int'(threshold), 0);
        chk("nest_ret_d0", int'(depth), 0);
        chk("nest_err0", int'(err), 0);

        // Overflow
        do_reset();
        cfg(0, 2, 1, 0); cfg(1, 4, 1, 0); cfg(2, 6, 1, 0);
        irq_src = 4'b0001; ticks(2); ack();
        irq_src = 4'b0011; ticks(2); ack();
        irq_src = 4'b0111; ticks(2);
        chk("ovf_id2", int'(irq_id), 2);
        ack();
        chk("ovf_err", int'(err), 1);
        chk("ovf_depth", int'(depth), 2);
        chk("ovf_thr", int'(threshold), 6);

        // Underflow
        do_reset();
        ret();
        chk("udf_err", int'(err), 1);
        chk("udf_thr", int'(threshold), 0);

`ifdef CLIC_EDGE_EN
        // Edge mode: pulse held until ack, second pulse in the ack cycle kept
        do_reset();
        cfg(1, 4, 1, 1);
        irq_src = 4'b0010; tick(); irq_src = '0; ticks(3);
        chk("edge_hold_req", int'(irq_req), 1);
        chk("edge_hold_id", int'(irq_id), 1);
        irq_src = 4'b0010; ack(); irq_src = '0;
        ticks(2);
        chk("edge_masked", int'(irq_req), 0);
        ret(); tick();
        chk("edge_reassert", int'(irq_req), 1);
        chk("edge_reassert_id", int'(irq_id), 1);
`endif

        // Tail-chain and ignored threshold write
        do_reset();
        cfg(3, 3, 1, 0); cfg(0, 5, 1, 0);
        irq_src = 4'b1000; ticks(2); ack();
        irq_src = 4'b1001; ticks(2);
        chk("tail_id0", int'(irq_id), 0);
        irq_ack = 1; irq_ret = 1; tick(); irq_ack = 0; irq_ret = 0;
        chk("tail_thr5", int'(threshold), 5);
        chk("tail_d1", int'(depth), 1);
        cfg(4, 1, 0, 0);
        chk("cfg_ignored_thr", int'(threshold), 5);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(3) == 0) irq_src[b] = ~irq_src[b];
            cfg_we   = ($urandom_range(3) == 0);
            cfg_idx  = IW'($urandom_range(N + 1));
            cfg_prio = PW'($urandom);
            cfg_en   = ($urandom_range(3) != 0);
            cfg_edge = ($urandom_range(1) == 1);
            irq_ack  = (m_req != 0) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            irq_ret  = ($urandom_range(5) == 0);
            if (irq_ack && irq_ret && m_stack.size() == 0) irq_ret = 0;
            if (cfg_we && int'(cfg_idx) == N && (irq_ack || irq_ret)) cfg_we = 0;
            rst = ($urandom_range(499) == 0);
            tick();
        end
        rst = 0; irq_ack = 0; irq_ret = 0; cfg_we = 0;
        tick();
        chk_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
